// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes CPU data accesses to either the word-only data RAM
// or a small IO page (LED, switches, 7-segment data, timer). Byte-masked
// stores to RAM are merged with the current read word. Loads are combinational.
module mmio_bridge #(
    parameter int          DRAM_AW       = 14,
    parameter int          SW_W          = 24,
    parameter int          LED_W         = 24,
    parameter logic [31:0] TIMER_DIV_RST = 32'd100000
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        cpu_addr,
    input  logic               cpu_we,
    input  logic [3:0]         cpu_sel,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic [DRAM_AW-1:0] dram_a,
    output logic               dram_we,
    output logic [31:0]        dram_d,
    input  logic [31:0]        dram_spo,
    input  logic [SW_W-1:0]    sw,
    output logic [LED_W-1:0]   led,
    output logic [31:0]        seg_data,
    output logic               seg_wr
);

    // IO word offsets within the 0xFFFFF page (byte offset >> 2)
    localparam logic [9:0] OFF_SEG  = 10'h000;
    localparam logic [9:0] OFF_TCNT = 10'h008;
    localparam logic [9:0] OFF_TDIV = 10'h009;
    localparam logic [9:0] OFF_LED  = 10'h018;
    localparam logic [9:0] OFF_SW   = 10'h01C;

    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      seg_q, seg_d;
    logic             seg_wr_q, seg_wr_d;
    logic [31:0]      tcnt_q, tcnt_d;
    logic [31:0]      pre_q, pre_d;
    logic [31:0]      tdiv_q, tdiv_d;
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;

    logic             io_hit, dram_hit, io_wr, tick;
    logic [9:0]       off;
    logic [31:0]      led_w;

    // Per-byte merge of a store into an existing word
    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    assign io_hit   = (cpu_addr[31:12] == 20'hFFFFF);
    assign dram_hit = ~io_hit;
    assign io_wr    = cpu_we & io_hit;
    assign off      = cpu_addr[11:2];

    // RAM side: address passthrough and read-modify-write merge
    assign dram_a  = cpu_addr[DRAM_AW+1:2];
    assign dram_we = cpu_we & dram_hit & (|cpu_sel);
    assign dram_d  = merge(dram_spo, cpu_wdata, cpu_sel);

    // Register next-state: stores, timer prescaler/counter, SEG write pulse
    always_comb begin
        led_d    = led_q;
        seg_d    = seg_q;
        seg_wr_d = 1'b0;
        tdiv_d   = tdiv_q;
        led_w    = merge(32'(led_q), cpu_wdata, cpu_sel);

        // TDIV==0 halts both prescaler and counter
        tick   = (tdiv_q != 32'd0) && (pre_q == tdiv_q - 32'd1);
        pre_d  = (tdiv_q == 32'd0) ? pre_q : (tick ? 32'd0 : pre_q + 32'd1);
        tcnt_d = tick ? tcnt_q + 32'd1 : tcnt_q;

        if (io_wr) begin
            case (off)
                OFF_SEG: begin
                    seg_d    = merge(seg_q, cpu_wdata, cpu_sel);
                    seg_wr_d = 1'b1;
                end
                // a store overrides a same-edge tick
                OFF_TCNT: tcnt_d = merge(tcnt_q, cpu_wdata, cpu_sel);
                OFF_TDIV: begin
                    tdiv_d = merge(tdiv_q, cpu_wdata, cpu_sel);
                    pre_d  = 32'd0;
                end
                OFF_LED:  led_d = led_w[LED_W-1:0];
                default:  ;
            endcase
        end
    end

    // Load data mux: unmapped IO offsets read as zero
    always_comb begin
        cpu_rdata = dram_spo;
        if (io_hit) begin
            case (off)
                OFF_SEG:  cpu_rdata = seg_q;
                OFF_TCNT: cpu_rdata = tcnt_q;
                OFF_TDIV: cpu_rdata = tdiv_q;
                OFF_LED:  cpu_rdata = 32'(led_q);
                OFF_SW:   cpu_rdata = 32'(sw_s2_q);
                default:  cpu_rdata = 32'd0;
            endcase
        end
    end

    // State registers; reset has priority over any store
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            led_q    <= '0;
            seg_q    <= '0;
            seg_wr_q <= 1'b0;
            tcnt_q   <= '0;
            pre_q    <= '0;
            tdiv_q   <= TIMER_DIV_RST;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            led_q    <= led_d;
            seg_q    <= seg_d;
            seg_wr_q <= seg_wr_d;
            tcnt_q   <= tcnt_d;
            pre_q    <= pre_d;
            tdiv_q   <= tdiv_d;
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    assign led      = led_q;
    assign seg_data = seg_q;
    assign seg_wr   = seg_wr_q;

    // Byte offset bits and LED store bits above LED_W are intentionally dropped
    logic unused_bits;
    assign unused_bits = ^{cpu_addr[1:0], led_w[31:LED_W]};

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;

    localparam int O_RD = 0, O_LED = 1, O_SEG = 2, O_SEGWR = 3, O_DWE = 4, O_DD = 5;
    localparam logic [31:0] A_SEG  = 32'hFFFFF000;
    localparam logic [31:0] A_NONE = 32'hFFFFF004;
    localparam logic [31:0] A_TCNT = 32'hFFFFF020;
    localparam logic [31:0] A_TDIV = 32'hFFFFF024;
    localparam logic [31:0] A_LED  = 32'hFFFFF060;
    localparam logic [31:0] A_SW   = 32'hFFFFF070;
    localparam logic [31:0] A_RAM  = 32'h00000100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dram_d, dram_spo, seg_data;
    logic        cpu_we, dram_we, seg_wr;
    logic [3:0]  cpu_sel;
    logic [13:0] dram_a;
    logic [23:0] sw, led;

    logic [31:0] mem [0:16383];

    mmio_bridge dut (
        .cpu_clk(clk), .cpu_rst(rst), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .dram_a(dram_a), .dram_we(dram_we), .dram_d(dram_d), .dram_spo(dram_spo),
        .sw(sw), .led(led), .seg_data(seg_data), .seg_wr(seg_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dram_we) mem[dram_a] <= dram_d;
    assign dram_spo = mem[dram_a];

    int          q_o[$];
    logic [31:0] q_e[$];
    string       q_n[$];
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] observe(input int o);
        case (o)
            O_RD:    return cpu_rdata;
            O_LED:   return 32'(led);
            O_SEG:   return seg_data;
            O_SEGWR: return 32'(seg_wr);
            O_DWE:   return 32'(dram_we);
            default: return dram_d;
        endcase
    endfunction

    int          m_o;
    logic [31:0] m_e, m_a;
    string       m_n;
    always @(negedge clk) begin
        while (q_o.size() > 0) begin
            m_o = q_o.pop_front();
            m_e = q_e.pop_front();
            m_n = q_n.pop_front();
            m_a = observe(m_o);
            total++;
            if (m_a !== m_e) begin
                bad++;
                $display("FAIL %s: got %h want %h", m_n, m_a, m_e);
            end
        end
    end

    task automatic chk(input logic c, input string n);
        total++;
        if (c !== 1'b1) begin
            bad++;
            $display("FAIL %s", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic expect_v(input int o, input logic [31:0] v, input string n);
        q_o.push_back(o);
        q_e.push_back(v);
        q_n.push_back(n);
    endtask

    task automatic drv(input logic [31:0] a, input logic we, input logic [3:0] sel,
                       input logic [31:0] d);
        cpu_addr  = a;
        cpu_we    = we;
        cpu_sel   = sel;
        cpu_wdata = d;
    endtask

    task automatic ld(input logic [31:0] a);
        drv(a, 1'b0, 4'b0000, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        drv(a, 1'b1, sel, d);
        step();
        ld(a);
    endtask

    logic seen;

    initial begin
        rst = 1'b1;
        sw  = '0;
        ld(A_RAM);
        step();
        step();
        rst = 1'b0;

        ld(A_TCNT);
        chk(led === 24'h0, "rst_led_direct");
        chk(seg_data === 32'h0, "rst_seg_direct");
        chk(seg_wr === 1'b0, "rst_segwr_direct");
        chk(cpu_rdata === 32'h0, "rst_tcnt_direct");
        expect_v(O_RD, 32'h0, "rst_tcnt");
        expect_v(O_LED, 32'h0, "rst_led");
        expect_v(O_SEG, 32'h0, "rst_seg");
        expect_v(O_SEGWR, 32'h0, "rst_segwr");
        step();
        ld(A_TDIV);
        expect_v(O_RD, 32'd100000, "rst_tdiv");
        step();

        st(A_RAM, 32'h11223344, 4'hF);
        expect_v(O_RD, 32'h11223344, "ram_init");
        step();
        drv(A_RAM, 1'b1, 4'b0101, 32'hAABBCCDD);
        expect_v(O_DWE, 32'h1, "ram_we_merge");
        expect_v(O_DD, 32'h11BB33DD, "ram_d_merge");
        step();
        ld(A_RAM);
        expect_v(O_RD, 32'h11BB33DD, "ram_rd_merge");
        expect_v(O_DWE, 32'h0, "ram_we_after");
        step();
        drv(A_RAM, 1'b1, 4'b0000, 32'hFFFFFFFF);
        expect_v(O_DWE, 32'h0, "ram_we_sel0");
        step();
        ld(A_RAM);
        expect_v(O_RD, 32'h11BB33DD, "ram_rd_sel0");
        step();

        st(A_LED, 32'h00FF00F0, 4'hF);
        expect_v(O_LED, 32'h00FF00F0, "led_full");
        expect_v(O_RD, 32'h00FF00F0, "led_rd");
        step();
        st(A_LED, 32'hAB000000, 4'b1000);
        expect_v(O_LED, 32'h00FF00F0, "led_byte3");
        step();
        st(A_LED, 32'h00001100, 4'b0010);
        expect_v(O_LED, 32'h00FF11F0, "led_byte1");
        step();

        drv(A_SEG, 1'b1, 4'hF, 32'h12345678);
        expect_v(O_SEGWR, 32'h0, "segwr_pre");
        step();
        ld(A_NONE);
        expect_v(O_SEG, 32'h12345678, "seg_data");
        expect_v(O_SEGWR, 32'h1, "segwr_pulse");
        expect_v(O_RD, 32'h0, "unmapped_rd");
        step();
        expect_v(O_SEGWR, 32'h0, "segwr_end");
        step();

        st(A_SW, 32'hFFFFFFFF, 4'hF);
        expect_v(O_RD, 32'h0, "sw_ro");
        step();
        sw = 24'h00A5A5;
        expect_v(O_RD, 32'h0, "sw_cyc0");
        step();
        expect_v(O_RD, 32'h0, "sw_cyc1");
        step();
        expect_v(O_RD, 32'h0000A5A5, "sw_cyc2");
        step();
        expect_v(O_RD, 32'h0000A5A5, "sw_cyc3");
        step();

        st(A_TCNT, 32'h0, 4'hF);
        drv(A_TDIV, 1'b1, 4'hF, 32'd3);
        step();
        ld(A_TCNT);
        for (int i = 0; i < 11; i++) step();
        expect_v(O_RD, 32'd3, "tdiv3_11cyc");
        step();
        expect_v(O_RD, 32'd4, "tdiv3_12cyc");
        step();

        st(A_TDIV, 32'h0, 4'hF);
        ld(A_TCNT);
        for (int i = 0; i < 20; i++) step();
        expect_v(O_RD, 32'd4, "tdiv0_frozen");
        step();

        st(A_TCNT, 32'hFFFFFFFF, 4'hF);
        expect_v(O_RD, 32'hFFFFFFFF, "tcnt_max");
        step();
        st(A_TDIV, 32'd1, 4'hF);
        ld(A_TCNT);
        expect_v(O_RD, 32'hFFFFFFFF, "tcnt_max_hold");
        step();
        expect_v(O_RD, 32'h0, "tcnt_wrap");
        step();
        expect_v(O_RD, 32'h1, "tcnt_after_wrap");

        drv(A_TCNT, 1'b1, 4'hF, 32'h50);
        step();
        ld(A_TCNT);
        expect_v(O_RD, 32'h50, "collide_store");
        step();
        expect_v(O_RD, 32'h51, "collide_next");
        step();

        st(A_TDIV, 32'd7, 4'hF);
        drv(A_SEG, 1'b1, 4'hF, 32'hFFFFFFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld(A_TCNT);
        chk(led === 24'h0, "mid_rst_led_direct");
        chk(seg_data === 32'h0, "mid_rst_seg_direct");
        chk(seg_wr === 1'b0, "mid_rst_segwr_direct");
        expect_v(O_RD, 32'h0, "mid_rst_tcnt");
        expect_v(O_LED, 32'h0, "mid_rst_led");
        expect_v(O_SEG, 32'h0, "mid_rst_seg");
        expect_v(O_SEGWR, 32'h0, "mid_rst_segwr");
        step();
        ld(A_TDIV);
        expect_v(O_RD, 32'd100000, "mid_rst_tdiv");
        step();
        ld(A_RAM);
        expect_v(O_RD, 32'h11BB33DD, "mid_rst_ram");
        step();
        step();

        drv(A_SEG, 1'b1, 4'hF, 32'h00000001);
        step();
        ld(A_NONE);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (seg_wr === 1'b1) seen = 1'b1;
            else step();
        end
        chk(seen, "segwr_wait_expired");
        step();
        step();

        chk(bad == 0, "summary_no_failures");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
